// File: rtl/reg_transfer_arbiter_pkg.sv
// Shared definitions for the register transfer arbiter.
//   NREG_DEF      : default number of general registers
//   IDX_W         : register index width
//   state_e       : transfer sequencer states
//   dst_protected : true when a write to dst must be suppressed
package reg_transfer_arbiter_pkg;

   localparam int NREG_DEF = 16;
   localparam int IDX_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   // Register 0 may be hard-wired; indices past the file do not exist.
   function automatic logic dst_protected(input logic [IDX_W-1:0] dst,
                                          input int nreg, input bit prot_r0);
      return (prot_r0 && (dst == '0)) || (int'(dst) >= nreg);
   endfunction

endpackage

// File: rtl/reg_transfer_arbiter_if.sv
// Handshake and register-bus bundle of the transfer arbiter.
//   req/src0/dst0/src1/dst1 : requester side (0 = control unit, 1 = debug port)
//   gnt/ack/err             : per-transfer status back to requesters
//   rd_en/rd_sel/wr_en/busy : register-file bus controls
// master = requesters / register file view, slave = arbiter view.
interface reg_transfer_arbiter_if
   import reg_transfer_arbiter_pkg::*;
   #(parameter int NREG = NREG_DEF) ();

   logic [1:0]       req;
   logic [IDX_W-1:0] src0, dst0, src1, dst1;
   logic [1:0]       gnt;
   logic [1:0]       ack;
   logic             rd_en;
   logic [IDX_W-1:0] rd_sel;
   logic [NREG-1:0]  wr_en;
   logic             busy;
   logic             err;

   modport master (output req, src0, dst0, src1, dst1,
                   input  gnt, ack, rd_en, rd_sel, wr_en, busy, err);

   modport slave  (input  req, src0, dst0, src1, dst1,
                   output gnt, ack, rd_en, rd_sel, wr_en, busy, err);

endinterface

// File: rtl/reg_transfer_arbiter_decoder.sv
// reg_decoder_4to16: register index + enable -> one-hot write strobe.
//   idx    : register index
//   en     : strobe enable; all outputs low when clear
//   onehot : NOUT-wide one-hot strobe
module reg_decoder_4to16
   import reg_transfer_arbiter_pkg::*;
   #(parameter int NOUT = NREG_DEF)
   (
      input  logic [IDX_W-1:0] idx,
      input  logic             en,
      output logic [NOUT-1:0]  onehot
   );

   for (genvar i = 0; i < NOUT; i++) begin : g_bit
      assign onehot[i] = en && (idx == IDX_W'(i));
   end

endmodule

// File: rtl/reg_transfer_arbiter.sv
// reg_transfer_arbiter: grants one of two requesters a register-to-register
// transfer (DRIVE source onto the bus, then WRITE it to dst), round-robin on
// contention, then acks the winner in the first IDLE cycle.
//   clk : clock
//   clr : synchronous active-low reset
//   bus : handshake + register bus (slave modport)
module reg_transfer_arbiter
   import reg_transfer_arbiter_pkg::*;
   #(
      parameter int NREG       = NREG_DEF,
      parameter bit PROTECT_R0 = 1'b1
   )
   (
      input  logic                  clk,
      input  logic                  clr,
      reg_transfer_arbiter_if.slave bus
   );

   state_e           state_q, state_d;
   logic             win_q, win_d;     // winner of current/last transfer
   logic             last_q;           // requester granted most recently
   logic [IDX_W-1:0] src_q, dst_q;
   logic             ack_q, err_q;
   logic             start;
   logic             prot;

   // A request seen in the ack cycle is deliberately ignored there.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      win_d   = 1'b0;
      unique case (bus.req)
         2'b10:   win_d = 1'b1;
         2'b11:   win_d = ~last_q;
         default: win_d = 1'b0;
      endcase
      unique case (state_q)
         ST_IDLE: begin
            if (|bus.req && !ack_q) begin
               start   = 1'b1;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign prot = dst_protected(dst_q, NREG, PROTECT_R0);

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;   // requester 0 wins the first contention
         src_q   <= '0;
         dst_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= (state_q == ST_WRITE);
         err_q   <= (state_q == ST_WRITE) && prot;
         if (start) begin
            win_q  <= win_d;
            last_q <= win_d;
            src_q  <= win_d ? bus.src1 : bus.src0;
            dst_q  <= win_d ? bus.dst1 : bus.dst0;
         end
      end
   end

   // win_q is stable through the ack cycle because start is blocked there.
   assign bus.busy   = (state_q != ST_IDLE);
   assign bus.gnt    = bus.busy ? (win_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.ack    = ack_q ? (win_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.err    = err_q;
   assign bus.rd_en  = bus.busy;
   assign bus.rd_sel = bus.busy ? src_q : '0;

   reg_decoder_4to16 #(.NOUT(NREG)) u_dec (
      .idx    (dst_q),
      .en     ((state_q == ST_WRITE) && !prot),
      .onehot (bus.wr_en)
   );

endmodule

// File: tb/tb_reg_transfer_arbiter.sv
// Bench for reg_transfer_arbiter: directed scenarios with literal expectations
// followed by randomized requesters, all cross-checked every cycle against a
// transaction-level model (a transfer started at cycle c owns the bus in
// c+1..c+2, writes in c+2, acks in c+3, and the next one may start at c+4).
module tb_reg_transfer_arbiter;

   localparam int NREG = 16;
   localparam bit PROT = 1'b1;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   reg_transfer_arbiter_if #(.NREG(NREG)) bus ();

   reg_transfer_arbiter #(.NREG(NREG), .PROTECT_R0(PROT)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]      gnt;
      logic [1:0]      ack;
      logic            rd_en;
      logic [3:0]      rd_sel;
      logic [NREG-1:0] wr_en;
      logic            busy;
      logic            err;
   } obs_t;

   // ---------------- reference model + compare ----------------
   obs_t        ring [8];
   int unsigned cyc     = 0;
   int unsigned free_at = 0;
   bit          last    = 1'b1;
   bit          mvalid  = 1'b0;

   task automatic model_step();
      obs_t act, e;
      int   w, s, d;
      bit   pr;
      act = '{gnt: bus.gnt, ack: bus.ack, rd_en: bus.rd_en, rd_sel: bus.rd_sel,
              wr_en: bus.wr_en, busy: bus.busy, err: bus.err};
      e = ring[cyc % 8];
      if (mvalid) begin
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL model cyc=%0d got gnt=%b ack=%b rd=%b sel=%0d wr=%h busy=%b err=%b want gnt=%b ack=%b rd=%b sel=%0d wr=%h busy=%b err=%b",
                     cyc, act.gnt, act.ack, act.rd_en, act.rd_sel, act.wr_en, act.busy, act.err,
                     e.gnt, e.ack, e.rd_en, e.rd_sel, e.wr_en, e.busy, e.err);
         end
      end
      ring[cyc % 8] = '0;
      if (!clr) begin
         for (int k = 0; k < 8; k++) ring[k] = '0;
         free_at = cyc + 1;
         last    = 1'b1;
         mvalid  = 1'b1;
      end else if (mvalid && bus.req != 2'b00 && cyc >= free_at) begin
         w  = (bus.req == 2'b11) ? int'(!last) : int'(bus.req[1]);
         s  = w ? int'(bus.src1) : int'(bus.src0);
         d  = w ? int'(bus.dst1) : int'(bus.dst0);
         pr = (PROT && d == 0) || d >= NREG;
         for (int k = 1; k <= 2; k++) begin
            ring[(cyc + k) % 8].gnt    = 2'(1 << w);
            ring[(cyc + k) % 8].rd_en  = 1'b1;
            ring[(cyc + k) % 8].rd_sel = 4'(s);
            ring[(cyc + k) % 8].busy   = 1'b1;
         end
         ring[(cyc + 2) % 8].wr_en = pr ? '0 : NREG'(1) << d;
         ring[(cyc + 3) % 8].ack   = 2'(1 << w);
         ring[(cyc + 3) % 8].err   = pr;
         free_at = cyc + 4;
         last    = w[0];
      end
      cyc++;
   endtask

   initial begin
      for (int k = 0; k < 8; k++) ring[k] = '0;
      forever begin
         @(negedge clk);
         model_step();
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output logic [1:0] a);
      a = 2'b00;
      for (int i = 0; i < 20 && a == 2'b00; i++) begin
         @(negedge clk);
         a = bus.ack;
      end
      if (a == 2'b00) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack want ack within 20 cycles");
      end
   endtask

   task automatic do_reset();
      clr = 1'b0;
      bus.req = 2'b00;
      tick();
      clr = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   logic [1:0] a;
   bit   [1:0] pend;
   logic       noack;

   initial begin
      clr = 1'b0;
      bus.req = 2'b00;
      bus.src0 = '0; bus.dst0 = '0; bus.src1 = '0; bus.dst1 = '0;
      tick();
      tick();
      @(negedge clk);
      chk("reset_outputs", 32'({bus.gnt, bus.ack, bus.rd_en, bus.rd_sel, bus.wr_en, bus.busy, bus.err}), 32'd0);
      tick();
      clr = 1'b1;

      // basic transfer 3 -> 5
      bus.req = 2'b01; bus.src0 = 4'd3; bus.dst0 = 4'd5;
      @(negedge clk); chk("c0_busy", 32'(bus.busy), 32'd0);
      @(negedge clk); chk("c1_gnt", 32'(bus.gnt), 32'd1);
                      chk("c1_rd_sel", 32'(bus.rd_sel), 32'd3);
                      chk("c1_wr_en", 32'(bus.wr_en), 32'd0);
      @(negedge clk); chk("c2_wr_en", 32'(bus.wr_en), 32'h20);
                      chk("c2_gnt", 32'(bus.gnt), 32'd1);
      @(negedge clk); chk("c3_ack", 32'(bus.ack), 32'd1);
                      chk("c3_gnt", 32'(bus.gnt), 32'd0);
      tick(); bus.req = 2'b00;
      repeat (3) tick();

      // contention after reset: 0 first, then 1
      do_reset();
      bus.req = 2'b11; bus.src0 = 4'd1; bus.dst0 = 4'd2; bus.src1 = 4'd6; bus.dst1 = 4'd8;
      wait_ack(a); chk("rr_first", 32'(a), 32'd1);
      wait_ack(a); chk("rr_second", 32'(a), 32'd2);
      tick(); bus.req = 2'b00;
      repeat (3) tick();

      // protected write to r0
      bus.req = 2'b01; bus.src0 = 4'd2; bus.dst0 = 4'd0;
      wait_ack(a); chk("prot_ack", 32'(a), 32'd1);
                   chk("prot_err", 32'(bus.err), 32'd1);
      tick(); bus.req = 2'b00;
      repeat (3) tick();

      // reset during WRITE
      bus.req = 2'b01; bus.src0 = 4'd5; bus.dst0 = 4'd6;
      tick();
      tick(); clr = 1'b0; bus.req = 2'b00;
      @(negedge clk); chk("rst_write_wr_en", 32'(bus.wr_en), 32'h40);
      tick(); clr = 1'b1;
      @(negedge clk);
      chk("rst_mid_all_zero", 32'({bus.gnt, bus.ack, bus.rd_en, bus.rd_sel, bus.wr_en, bus.busy, bus.err}), 32'd0);
      noack = 1'b0;
      repeat (5) begin @(negedge clk); noack = noack | (|bus.ack); end
      chk("rst_mid_no_ack", 32'(noack), 32'd0);
      tick();

      // drop req and change operands during DRIVE
      bus.req = 2'b01; bus.src0 = 4'd4; bus.dst0 = 4'd7;
      tick(); bus.req = 2'b00; bus.src0 = 4'd9;
      @(negedge clk); chk("drop_c1_rd_sel", 32'(bus.rd_sel), 32'd4);
      @(negedge clk); chk("drop_c2_wr_en", 32'(bus.wr_en), 32'h80);
      @(negedge clk); chk("drop_c3_ack", 32'(bus.ack), 32'd1);
      repeat (2) tick();

      // randomized requesters that follow the hold-until-ack protocol
      pend = 2'b00;
      for (int n = 0; n < 4000; n++) begin
         tick();
         if ($urandom_range(0, 299) == 0) begin
            clr = 1'b0; bus.req = 2'b00; pend = 2'b00;
            continue;
         end
         clr = 1'b1;
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && bus.ack[i]) begin
               pend[i] = 1'b0;
               bus.req[i] = ($urandom_range(0, 3) == 0);
            end else if (pend[i] && bus.gnt[i] && $urandom_range(0, 9) == 0) begin
               bus.req[i] = 1'b0;
               if (i == 0) bus.src0 = 4'($urandom); else bus.src1 = 4'($urandom);
            end else if (!pend[i] && !bus.req[i] && $urandom_range(0, 2) == 0) begin
               bus.req[i] = 1'b1;
            end
            if (!pend[i] && bus.req[i]) begin
               pend[i] = 1'b1;
               if (i == 0) begin bus.src0 = 4'($urandom); bus.dst0 = 4'($urandom); end
               else        begin bus.src1 = 4'($urandom); bus.dst1 = 4'($urandom); end
            end
         end
      end
      clr = 1'b1; bus.req = 2'b00;
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
